// File: rtl/line_window_buffer_if.sv
// Stream bundle for the line window buffer: pixel input side and column output side.
// slave is the buffer's view, master is the source/sink view.
interface line_window_buffer_if #(
    parameter int PIX_W = 8,
    parameter int ROWS  = 5
);
    logic [PIX_W-1:0]      in_data;
    logic                  in_sof;
    logic                  in_valid;
    logic                  in_ready;
    logic [ROWS*PIX_W-1:0] out_data;
    logic                  out_eol;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  in_data, in_sof, in_valid, out_ready,
        output in_ready, out_data, out_eol, out_valid
    );

    modport master (
        output in_data, in_sof, in_valid, out_ready,
        input  in_ready, out_data, out_eol, out_valid
    );
endinterface

// File: rtl/line_window_buffer.sv
// Purpose: ROWS-high line buffer; emits one vertical pixel column per accepted pixel.
// Latency: accept at cycle t -> out_valid at t+1, one pixel per cycle sustained.
// Backpressure: single output register; in_ready = !out_valid | out_ready, output held while stalled.
module line_window_buffer #(
    parameter int PIX_W  = 8,
    parameter int LINE_W = 420,
    parameter int ROWS   = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    line_window_buffer_if.slave bus
);
    localparam int CW = $clog2(LINE_W);
    localparam int NM = ROWS - 1;
    localparam int RW = (NM > 1) ? $clog2(NM) : 1;
    localparam int FW = $clog2(ROWS);

    logic [PIX_W-1:0] mem [NM][LINE_W];

    logic [CW-1:0]         col;
    logic [RW-1:0]         wr_row;
    logic [FW-1:0]         fill;
    logic                  out_valid_q;
    logic                  out_eol_q;
    logic [ROWS*PIX_W-1:0] out_data_q;

    logic                  accept;
    logic [CW-1:0]         eff_col;
    logic [RW-1:0]         eff_row;
    logic [FW-1:0]         eff_fill;
    logic                  last;
    logic [ROWS*PIX_W-1:0] col_vec;

    // Line memory holding the line k rows after the oldest one, wrapping over NM memories.
    function automatic logic [RW-1:0] row_sel(input logic [RW-1:0] base, input int k);
        logic [RW:0] s;
        s = {1'b0, base} + (RW+1)'(k);
        if (s >= (RW+1)'(NM)) begin
            s = s - (RW+1)'(NM);
        end
        return s[RW-1:0];
    endfunction

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.out_data  = out_data_q;

    assign accept   = bus.in_valid && bus.in_ready;
    // A start-of-frame pixel restarts at column 0 with no buffered lines, even mid-line.
    assign eff_col  = bus.in_sof ? '0 : col;
    assign eff_row  = bus.in_sof ? '0 : wr_row;
    assign eff_fill = bus.in_sof ? '0 : fill;
    assign last     = (eff_col == CW'(LINE_W - 1));

    always_comb begin
        col_vec = '0;
        for (int k = 0; k < NM; k++) begin
            col_vec[k*PIX_W +: PIX_W] = mem[row_sel(eff_row, k)][eff_col];
        end
        col_vec[NM*PIX_W +: PIX_W] = bus.in_data;
    end

    // Memory has no reset: fill gates whether stale contents can ever reach the output.
    always_ff @(posedge clock) begin
        if (reset_n && accept) begin
            mem[eff_row][eff_col] <= bus.in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            col         <= '0;
            wr_row      <= '0;
            fill        <= '0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_data_q  <= '0;
        end else if (accept) begin
            if (last) begin
                col    <= '0;
                wr_row <= row_sel(eff_row, 1);
                fill   <= (eff_fill == FW'(NM)) ? eff_fill : eff_fill + 1'b1;
            end else begin
                col    <= eff_col + 1'b1;
                wr_row <= eff_row;
                fill   <= eff_fill;
            end
            if (eff_fill == FW'(NM)) begin
                out_valid_q <= 1'b1;
                out_data_q  <= col_vec;
                out_eol_q   <= last;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench: small 8x3 instance for frame/stall/restart/reset cases, default instance for a full frame.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_line_window_buffer;
    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    line_window_buffer_if #(.PIX_W(8), .ROWS(3)) s_if ();
    line_window_buffer_if #(.PIX_W(8), .ROWS(5)) b_if ();

    line_window_buffer #(.PIX_W(8), .LINE_W(8), .ROWS(3)) u_small (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (s_if)
    );

    line_window_buffer #(.PIX_W(8), .LINE_W(420), .ROWS(5)) u_big (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (b_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] s_pix(input int l, input int c);
        return 8'(16 * l + c);
    endfunction

    function automatic logic [7:0] b_pix(input int l, input int c);
        return 8'(l * 37 + c * 11 + c / 7);
    endfunction

    // Small-instance output log: {eol, data}
    logic [24:0] s_q [$];
    always @(negedge clock) begin
        if (s_if.out_valid && s_if.out_ready) begin
            s_q.push_back({s_if.out_eol, s_if.out_data});
        end
    end

    // Default-instance golden column model: output n is line 4 + n/420, column n%420.
    int          b_cnt;
    int          bl;
    int          bc;
    logic [39:0] be;
    always @(negedge clock) begin
        if (b_if.out_valid && b_if.out_ready) begin
            bl = 4 + b_cnt / 420;
            bc = b_cnt % 420;
            for (int k = 0; k < 5; k++) begin
                be[k*8 +: 8] = b_pix(bl - 4 + k, bc);
            end
            chk("b_data", b_if.out_data, be);
            chk("b_eol", b_if.out_eol, bc == 419);
            b_cnt++;
        end
    end

    logic rnd_en;
    always @(posedge clock) begin
        #1;
        if (rnd_en) begin
            b_if.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Callers are always at rising edge + 1.
    task automatic send_s(input logic [7:0] d, input logic sof);
        int n;
        n = 0;
        s_if.in_data  = d;
        s_if.in_sof   = sof;
        s_if.in_valid = 1'b1;
        @(negedge clock);
        while (!s_if.in_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) chk("s_timeout", n, 0);
        @(posedge clock);
        #1;
        s_if.in_valid = 1'b0;
        s_if.in_sof   = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic sof);
        int n;
        n = 0;
        b_if.in_data  = d;
        b_if.in_sof   = sof;
        b_if.in_valid = 1'b1;
        @(negedge clock);
        while (!b_if.in_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) chk("b_timeout", n, 0);
        @(posedge clock);
        #1;
        b_if.in_valid = 1'b0;
        b_if.in_sof   = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [24:0] e;
        int          l;
        int          c;
        int          n;
        checks   = 0;
        failures = 0;
        b_cnt    = 0;
        rnd_en   = 1'b0;
        reset_n  = 1'b0;
        s_if.in_data = '0; s_if.in_sof = 1'b0; s_if.in_valid = 1'b0; s_if.out_ready = 1'b1;
        b_if.in_data = '0; b_if.in_sof = 1'b0; b_if.in_valid = 1'b0; b_if.out_ready = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", s_if.out_valid, 0);
        chk("rst_data", s_if.out_data, 0);
        chk("rst_eol", s_if.out_eol, 0);
        chk("rst_in_ready", s_if.in_ready, 1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Frame A: 6 lines, stall of 5 cycles during line 3.
        for (int li = 0; li < 6; li++) begin
            for (int ci = 0; ci < 8; ci++) begin
                if (li == 3 && ci == 3) begin
                    s_if.out_ready = 1'b0;
                    s_if.in_data   = s_pix(3, 3);
                    s_if.in_valid  = 1'b1;
                    repeat (5) begin
                        @(negedge clock);
                        chk("stall_in_ready", s_if.in_ready, 0);
                        chk("stall_data", s_if.out_data, 24'h322212);
                    end
                    @(posedge clock);
                    #1;
                    s_if.out_ready = 1'b1;
                end
                send_s(s_pix(li, ci), li == 0 && ci == 0);
                if (li == 1 && ci == 7) begin
                    settle();
                    chk("a_idle_fill", s_q.size(), 0);
                end
                if (li == 2 && ci == 0) begin
                    @(negedge clock);
                    chk("a_first_vld", s_if.out_valid, 1);
                    chk("a_first_dat", s_if.out_data, 24'h201000);
                    @(posedge clock);
                    #1;
                end
            end
        end
        settle();
        chk("a_count", s_q.size(), 32);
        for (int i = 0; i < s_q.size(); i++) begin
            l = 2 + i / 8;
            c = i % 8;
            e = {c == 7, s_pix(l, c), s_pix(l - 1, c), s_pix(l - 2, c)};
            chk("a_col", s_q[i], e);
        end
        chk("a_l5c3", s_q[27], {1'b0, 24'h534333});

        // Frame B: restart via sof at line 3 column 4.
        s_q.delete();
        for (int li = 0; li < 4; li++) begin
            for (int ci = 0; ci < 8; ci++) begin
                if (!(li == 3 && ci >= 4)) send_s(s_pix(li, ci), li == 0 && ci == 0);
            end
        end
        settle();
        chk("b_pre_count", s_q.size(), 12);
        chk("b_pre_last", s_q[11], {1'b0, 24'h332313});
        s_q.delete();
        for (int li = 0; li < 3; li++) begin
            for (int ci = 0; ci < 8; ci++) begin
                send_s(8'h80 + s_pix(li, ci), li == 0 && ci == 0);
            end
            if (li == 1) begin
                settle();
                chk("sof_idle", s_q.size(), 0);
            end
        end
        settle();
        chk("sof_count", s_q.size(), 8);
        chk("sof_first", s_q[0], {1'b0, 24'hA09080});
        chk("sof_last", s_q[7], {1'b1, 24'hA79787});

        // Reset while an output is held.
        s_if.out_ready = 1'b0;
        send_s(8'hB0, 1'b0);
        @(negedge clock);
        chk("hold_vld", s_if.out_valid, 1);
        chk("hold_dat", s_if.out_data, 24'hB0A090);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("mid_rst_vld", s_if.out_valid, 0);
        chk("mid_rst_dat", s_if.out_data, 0);
        chk("mid_rst_eol", s_if.out_eol, 0);
        @(posedge clock);
        #1;
        s_if.out_ready = 1'b1;
        s_q.delete();
        for (int li = 0; li < 2; li++) begin
            for (int ci = 0; ci < 8; ci++) begin
                send_s(8'hC0 + s_pix(li, ci), 1'b0);
            end
        end
        settle();
        chk("post_rst_idle", s_q.size(), 0);
        send_s(8'hE0, 1'b0);
        settle();
        chk("post_rst_count", s_q.size(), 1);
        chk("post_rst_first", s_q[0], {1'b0, 24'hE0D0C0});

        // Default instance: 20-line frame with random downstream stalls.
        rnd_en = 1'b1;
        for (int li = 0; li < 20; li++) begin
            for (int ci = 0; ci < 420; ci++) begin
                send_b(b_pix(li, ci), li == 0 && ci == 0);
            end
        end
        n = 0;
        while (b_cnt < 6720 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        rnd_en = 1'b0;
        @(posedge clock);
        #1;
        b_if.out_ready = 1'b1;
        repeat (5) @(negedge clock);
        chk("b_count", b_cnt, 6720);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
